// File: rtl/itrace_expander.sv
`timescale 1ns/1ps
// Re-expands one compressed trace block into one record per retired instruction,
// recovering each instruction's size through a one-outstanding image lookup.
module itrace_expander #(
  parameter int XLEN        = 32,
  parameter int IRETIRE_LEN = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int PRIV_LEN    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [IRETIRE_LEN-1:0] iretire_i,
  input  logic                   ilastsize_i,
  input  logic [ITYPE_LEN-1:0]   itype_i,
  input  logic [XLEN-1:0]        cause_i,
  input  logic [XLEN-1:0]        tval_i,
  input  logic [XLEN-1:0]        iaddr_i,
  input  logic [PRIV_LEN-1:0]    priv_i,
  output logic                   img_req_o,
  output logic [XLEN-1:0]        img_addr_o,
  input  logic                   img_rsp_valid_i,
  input  logic                   img_compressed_i,
  output logic                   inst_valid_o,
  input  logic                   inst_ready_i,
  output logic [XLEN-1:0]        inst_pc_o,
  output logic                   inst_compressed_o,
  output logic                   inst_last_o,
  output logic                   inst_event_only_o,
  output logic [ITYPE_LEN-1:0]   inst_itype_o,
  output logic [XLEN-1:0]        inst_cause_o,
  output logic [XLEN-1:0]        inst_tval_o,
  output logic [PRIV_LEN-1:0]    inst_priv_o,
  output logic                   err_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] EMIT  = 2'd3;

  // Instruction length in 16-bit retirement units.
  function automatic logic [IRETIRE_LEN-1:0] inst_units(input logic compressed);
    return compressed ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
  endfunction

  logic [1:0]             state_q;
  logic [XLEN-1:0]        pc_q;
  logic [IRETIRE_LEN-1:0] rem_q;

  logic                   lastsize_q;
  logic [ITYPE_LEN-1:0]   itype_q;
  logic [XLEN-1:0]        cause_q;
  logic [XLEN-1:0]        tval_q;
  logic [PRIV_LEN-1:0]    priv_q;

  logic [XLEN-1:0]        rec_pc_q;
  logic                   rec_c_q;
  logic                   rec_last_q;
  logic                   rec_ev_q;
  logic [ITYPE_LEN-1:0]   rec_itype_q;
  logic [XLEN-1:0]        rec_cause_q;
  logic [XLEN-1:0]        rec_tval_q;
  logic [PRIV_LEN-1:0]    rec_priv_q;
  logic                   rec_err_q;

  logic [IRETIRE_LEN-1:0] rsp_units;
  logic                   rsp_last;
  logic                   rsp_overrun;
  logic                   rsp_size_err;
  logic                   rsp_err;

  assign rsp_units    = inst_units(img_compressed_i);
  assign rsp_last     = rsp_units >= rem_q;
  assign rsp_overrun  = rsp_units > rem_q;
  // The final instruction's size must agree with the block's ilastsize.
  assign rsp_size_err = rsp_last && (!img_compressed_i != lastsize_q);
  assign rsp_err      = rsp_overrun || rsp_size_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            pc_q    <= iaddr_i;
            rem_q   <= iretire_i;
            state_q <= (iretire_i == '0) ? EMIT : FETCH;
          end
        end
        FETCH: state_q <= WAIT;
        WAIT: begin
          if (img_rsp_valid_i) state_q <= EMIT;
        end
        EMIT: begin
          if (inst_ready_i) begin
            if (rec_last_q) begin
              state_q <= IDLE;
            end else begin
              rem_q   <= rem_q - inst_units(rec_c_q);
              pc_q    <= pc_q + (rec_c_q ? XLEN'(2) : XLEN'(4));
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Block fields and the record under construction; outputs are gated by valid.
  always_ff @(posedge clk_i) begin
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          lastsize_q  <= ilastsize_i;
          itype_q     <= itype_i;
          cause_q     <= cause_i;
          tval_q      <= tval_i;
          priv_q      <= priv_i;
          rec_pc_q    <= iaddr_i;
          rec_c_q     <= 1'b0;
          rec_last_q  <= 1'b1;
          rec_ev_q    <= 1'b1;
          rec_itype_q <= itype_i;
          rec_cause_q <= cause_i;
          rec_tval_q  <= tval_i;
          rec_priv_q  <= priv_i;
          rec_err_q   <= 1'b0;
        end
      end
      WAIT: begin
        if (img_rsp_valid_i) begin
          rec_pc_q    <= pc_q;
          rec_c_q     <= img_compressed_i;
          rec_last_q  <= rsp_last || rsp_err;
          rec_ev_q    <= 1'b0;
          rec_itype_q <= rsp_last ? itype_q : '0;
          rec_cause_q <= rsp_last ? cause_q : '0;
          rec_tval_q  <= rsp_last ? tval_q : '0;
          rec_priv_q  <= priv_q;
          rec_err_q   <= rsp_err;
        end
      end
      default: ;
    endcase
  end

  assign ready_o           = (state_q == IDLE);
  assign img_req_o         = (state_q == FETCH);
  assign img_addr_o        = img_req_o ? pc_q : '0;
  assign inst_valid_o      = (state_q == EMIT);
  assign inst_pc_o         = inst_valid_o ? rec_pc_q : '0;
  assign inst_compressed_o = inst_valid_o & rec_c_q;
  assign inst_last_o       = inst_valid_o & rec_last_q;
  assign inst_event_only_o = inst_valid_o & rec_ev_q;
  assign inst_itype_o      = inst_valid_o ? rec_itype_q : '0;
  assign inst_cause_o      = inst_valid_o ? rec_cause_q : '0;
  assign inst_tval_o       = inst_valid_o ? rec_tval_q : '0;
  assign inst_priv_o       = inst_valid_o ? rec_priv_q : '0;
  assign err_o             = inst_valid_o & rec_err_q;

endmodule

// File: tb/tb_itrace_expander.sv
`timescale 1ns/1ps
// Bench for itrace_expander: directed table, hand-written timing/reset sequences,
// and randomized blocks against a behavioural model with a reactive image responder.
module tb_itrace_expander;
  localparam int XLEN = 32;
  localparam int IRL  = 32;
  localparam int ITL  = 3;
  localparam int PL   = 2;

  logic            clk_i, rst_ni, valid_i, ready_o, ilastsize_i;
  logic [IRL-1:0]  iretire_i;
  logic [ITL-1:0]  itype_i;
  logic [XLEN-1:0] cause_i, tval_i, iaddr_i;
  logic [PL-1:0]   priv_i;
  logic            img_req_o, img_rsp_valid_i, img_compressed_i;
  logic [XLEN-1:0] img_addr_o;
  logic            inst_valid_o, inst_ready_i, inst_compressed_o, inst_last_o;
  logic            inst_event_only_o, err_o;
  logic [XLEN-1:0] inst_pc_o, inst_cause_o, inst_tval_o;
  logic [ITL-1:0]  inst_itype_o;
  logic [PL-1:0]   inst_priv_o;

  itrace_expander #(.XLEN(XLEN), .IRETIRE_LEN(IRL), .ITYPE_LEN(ITL), .PRIV_LEN(PL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i),
    .cause_i(cause_i), .tval_i(tval_i), .iaddr_i(iaddr_i), .priv_i(priv_i),
    .img_req_o(img_req_o), .img_addr_o(img_addr_o), .img_rsp_valid_i(img_rsp_valid_i),
    .img_compressed_i(img_compressed_i), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .inst_pc_o(inst_pc_o), .inst_compressed_o(inst_compressed_o),
    .inst_last_o(inst_last_o), .inst_event_only_o(inst_event_only_o),
    .inst_itype_o(inst_itype_o), .inst_cause_o(inst_cause_o), .inst_tval_o(inst_tval_o),
    .inst_priv_o(inst_priv_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0] iaddr;
    logic [IRL-1:0]  iretire;
    logic            ls;
    logic [ITL-1:0]  itype;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic [PL-1:0]   priv;
  } blk_t;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            c, last, ev, err;
    logic [ITL-1:0]  itype;
    logic [XLEN-1:0] cause, tval;
    logic [PL-1:0]   priv;
  } rec_t;

  typedef struct {
    blk_t                  b;
    logic [3:0]            imgc;
    int                    n;
    logic [3:0][XLEN-1:0]  pcs;
    logic                  ev;
    logic                  err_last;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t exp_q[$];
  bit   img_mem [logic [XLEN-1:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic img_lookup(input logic [XLEN-1:0] a);
    if (img_mem.exists(a)) return img_mem[a];
    return 1'b0;
  endfunction

  // Image responder: answers each strobe after fixed_delay cycles (random when < 0),
  // optionally injecting spurious responses while no lookup is outstanding.
  int              fixed_delay = 0;
  bit              spurious_en = 0;
  bit              rsp_pend    = 0;
  int              rsp_wait    = 0;
  int              req_count   = 0;
  logic [XLEN-1:0] rsp_addr    = '0;

  always @(negedge clk_i) begin
    img_rsp_valid_i  = 1'b0;
    img_compressed_i = 1'($urandom_range(0, 1));
    if (rsp_pend) begin
      if (rsp_wait == 0) begin
        img_rsp_valid_i  = 1'b1;
        img_compressed_i = img_lookup(rsp_addr);
        rsp_pend         = 0;
      end else begin
        rsp_wait--;
      end
    end else if (spurious_en && !img_req_o && $urandom_range(0, 3) == 0) begin
      img_rsp_valid_i = 1'b1;
    end
    if (img_req_o) begin
      rsp_pend  = 1;
      rsp_addr  = img_addr_o;
      rsp_wait  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      req_count++;
    end
  end

  function automatic vec_t mk(input logic [XLEN-1:0] iaddr, input logic [IRL-1:0] ir,
                              input logic ls, input logic [ITL-1:0] it,
                              input logic [XLEN-1:0] cause, input logic [XLEN-1:0] tval,
                              input logic [PL-1:0] priv, input logic [3:0] imgc, input int n,
                              input logic [XLEN-1:0] p0, input logic [XLEN-1:0] p1,
                              input logic [XLEN-1:0] p2, input logic [XLEN-1:0] p3,
                              input logic ev, input logic err_last);
    vec_t v;
    v.b.iaddr = iaddr; v.b.iretire = ir; v.b.ls = ls; v.b.itype = it;
    v.b.cause = cause; v.b.tval = tval; v.b.priv = priv;
    v.imgc = imgc; v.n = n; v.ev = ev; v.err_last = err_last;
    v.pcs[0] = p0; v.pcs[1] = p1; v.pcs[2] = p2; v.pcs[3] = p3;
    return v;
  endfunction

  // Expected records straight from the block rules, in unit arithmetic.
  task automatic model_block(input blk_t b);
    rec_t            r;
    logic [XLEN-1:0] pc;
    longint          rem;
    int              sz;
    exp_q.delete();
    r.priv = b.priv;
    if (b.iretire == '0) begin
      r.pc = b.iaddr; r.c = 1'b0; r.last = 1'b1; r.ev = 1'b1; r.err = 1'b0;
      r.itype = b.itype; r.cause = b.cause; r.tval = b.tval;
      exp_q.push_back(r);
      return;
    end
    pc  = b.iaddr;
    rem = longint'(b.iretire);
    for (int k = 0; k < 64; k++) begin
      r.c    = img_lookup(pc);
      sz     = r.c ? 1 : 2;
      r.pc   = pc;
      r.ev   = 1'b0;
      r.last = (sz >= rem);
      r.err  = (sz > rem) || (r.last && (b.ls == r.c));
      r.itype = r.last ? b.itype : '0;
      r.cause = r.last ? b.cause : '0;
      r.tval  = r.last ? b.tval : '0;
      exp_q.push_back(r);
      if (r.last) break;
      rem = rem - sz;
      pc  = pc + XLEN'(2 * sz);
    end
  endtask

  task automatic table_expected(input vec_t v);
    rec_t r;
    exp_q.delete();
    img_mem.delete();
    for (int i = 0; i < v.n; i++) begin
      if (!v.ev) img_mem[v.pcs[i]] = v.imgc[i];
      r.pc    = v.pcs[i];
      r.c     = v.ev ? 1'b0 : v.imgc[i];
      r.last  = (i == v.n - 1);
      r.ev    = v.ev;
      r.err   = r.last && v.err_last;
      r.itype = r.last ? v.b.itype : '0;
      r.cause = r.last ? v.b.cause : '0;
      r.tval  = r.last ? v.b.tval : '0;
      r.priv  = v.b.priv;
      exp_q.push_back(r);
    end
  endtask

  task automatic drive_blk(input blk_t b);
    valid_i = 1'b1; iaddr_i = b.iaddr; iretire_i = b.iretire; ilastsize_i = b.ls;
    itype_i = b.itype; cause_i = b.cause; tval_i = b.tval; priv_i = b.priv;
  endtask

  task automatic cmp_rec(input string tag, input rec_t e);
    chk({tag, "_pc"},    64'(inst_pc_o),         64'(e.pc));
    chk({tag, "_c"},     64'(inst_compressed_o), 64'(e.c));
    chk({tag, "_last"},  64'(inst_last_o),       64'(e.last));
    chk({tag, "_ev"},    64'(inst_event_only_o), 64'(e.ev));
    chk({tag, "_err"},   64'(err_o),             64'(e.err));
    chk({tag, "_itype"}, 64'(inst_itype_o),      64'(e.itype));
    chk({tag, "_cause"}, 64'(inst_cause_o),      64'(e.cause));
    chk({tag, "_tval"},  64'(inst_tval_o),       64'(e.tval));
    chk({tag, "_priv"},  64'(inst_priv_o),       64'(e.priv));
  endtask

  // Presents one block and consumes its records against exp_q.
  task automatic run_block(input blk_t b, input int ready_pct, input string tag);
    int got, bound, req_base, n_fetch;
    bit done;
    got = 0; bound = 0; done = 0; n_fetch = 0;
    foreach (exp_q[i]) if (!exp_q[i].ev) n_fetch++;
    while (!ready_o && bound < 50) begin
      @(negedge clk_i);
      bound++;
    end
    chk({tag, "_ready_before"}, 64'(ready_o), 64'(1));
    req_base = req_count;
    drive_blk(b);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk({tag, "_ready_after_accept"}, 64'(ready_o), 64'(0));
    bound = 0;
    while (!done && bound < 400) begin
      inst_ready_i = 1'b0;
      if (inst_valid_o) begin
        chk({tag, "_busy"}, 64'({ready_o, img_req_o}), 64'(0));
        if (int'($urandom_range(0, 99)) < ready_pct) begin
          if (got < exp_q.size()) cmp_rec(tag, exp_q[got]);
          else chk({tag, "_extra_record"}, 64'(1), 64'(0));
          got++;
          if (inst_last_o) done = 1;
          inst_ready_i = 1'b1;
        end
      end
      @(negedge clk_i);
      bound++;
    end
    inst_ready_i = 1'b0;
    chk({tag, "_completed"},  64'(done),    64'(1));
    chk({tag, "_nrecords"},   64'(got),     64'(exp_q.size()));
    chk({tag, "_ready_end"},  64'(ready_o), 64'(1));
    chk({tag, "_nlookups"},   64'(req_count - req_base), 64'(n_fetch));
  endtask

  function automatic logic any_out();
    return |{inst_valid_o, inst_pc_o, inst_compressed_o, inst_last_o, inst_event_only_o,
             inst_itype_o, inst_cause_o, inst_tval_o, inst_priv_o, err_o, img_req_o, img_addr_o};
  endfunction

  vec_t            tv[7];
  blk_t            b;
  logic [XLEN-1:0] snap;
  logic [3:0]      snap_f;
  logic [XLEN-1:0] tmp;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; inst_ready_i = 1'b0;
    iretire_i = '0; ilastsize_i = 1'b0; itype_i = '0;
    cause_i = '0; tval_i = '0; iaddr_i = '0; priv_i = '0;

    tv[0] = mk(32'h1000, 6, 1, 3, 0, 0, 3, 4'b0101, 4, 32'h1000, 32'h1002, 32'h1006, 32'h1008, 0, 0);
    tv[1] = mk(32'h2000, 0, 0, 1, 2, 32'hDEAD, 1, 4'b0000, 1, 32'h2000, 0, 0, 0, 1, 0);
    tv[2] = mk(32'h3000, 1, 1, 0, 5, 7, 0, 4'b0000, 1, 32'h3000, 0, 0, 0, 0, 1);
    tv[3] = mk(32'h4000, 2, 1, 0, 0, 0, 2, 4'b0011, 2, 32'h4000, 32'h4002, 0, 0, 0, 1);
    tv[4] = mk(32'hFFFF_FFFE, 2, 0, 2, 32'hB, 32'h44, 2, 4'b0011, 2, 32'hFFFF_FFFE, 32'h0, 0, 0, 0, 0);
    tv[5] = mk(32'h5000, 2, 1, 0, 0, 0, 1, 4'b0000, 1, 32'h5000, 0, 0, 0, 0, 0);
    tv[6] = mk(32'h5100, 3, 0, 2, 9, 3, 3, 4'b0001, 2, 32'h5100, 32'h5102, 0, 0, 0, 1);

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_ready", 64'(ready_o), 64'(1));
    chk("rst_outputs_zero", 64'(any_out()), 64'(0));
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", 64'(ready_o), 64'(1));
    chk("post_rst_outputs_zero", 64'(any_out()), 64'(0));

    // Directed table
    fixed_delay = -1;
    spurious_en = 1;
    for (int i = 0; i < 7; i++) begin
      table_expected(tv[i]);
      run_block(tv[i].b, 70, $sformatf("vec%0d", i));
    end

    // Latency and backpressure on the first record of a two-record block
    spurious_en = 0;
    fixed_delay = 0;
    img_mem.delete();
    img_mem[32'h6000] = 1'b1;
    img_mem[32'h6002] = 1'b1;
    b.iaddr = 32'h6000; b.iretire = 2; b.ls = 0; b.itype = 0; b.cause = 0; b.tval = 0; b.priv = 1;
    drive_blk(b);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("lat_req_t1", 64'(img_req_o), 64'(1));
    chk("lat_addr_t1", 64'(img_addr_o), 64'(32'h6000));
    @(negedge clk_i);
    chk("lat_t2_state", 64'({inst_valid_o, img_req_o}), 64'(0));
    @(negedge clk_i);
    chk("lat_valid_t3", 64'(inst_valid_o), 64'(1));
    chk("lat_pc_t3", 64'(inst_pc_o), 64'(32'h6000));
    chk("lat_last_t3", 64'(inst_last_o), 64'(0));
    snap   = inst_pc_o;
    snap_f = {inst_compressed_o, inst_last_o, inst_priv_o == 2'd1, err_o};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("bp_pc_stable", 64'(inst_pc_o), 64'(snap));
      chk("bp_flags_stable", 64'({inst_compressed_o, inst_last_o, inst_priv_o == 2'd1, err_o}), 64'(snap_f));
      chk("bp_quiet", 64'({inst_valid_o, img_req_o, ready_o}), 64'(3'b100));
    end
    inst_ready_i = 1'b1;
    @(negedge clk_i);
    inst_ready_i = 1'b0;
    chk("bp_next_req", 64'(img_req_o), 64'(1));
    chk("bp_next_addr", 64'(img_addr_o), 64'(32'h6002));
    repeat (2) @(negedge clk_i);
    chk("bp_rec2", 64'({inst_valid_o, inst_last_o, err_o, inst_pc_o}), 64'({3'b110, 32'h6002}));
    inst_ready_i = 1'b1;
    @(negedge clk_i);
    inst_ready_i = 1'b0;
    chk("bp_done", 64'({ready_o, inst_valid_o}), 64'(2'b10));

    // Event-only latency
    b.iaddr = 32'h2100; b.iretire = 0; b.itype = 2; b.cause = 32'h8000_0007; b.tval = 0; b.priv = 3;
    drive_blk(b);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("ev_valid_t1", 64'({inst_valid_o, inst_event_only_o, inst_last_o, img_req_o}), 64'(4'b1110));
    chk("ev_cause", 64'(inst_cause_o), 64'(32'h8000_0007));
    inst_ready_i = 1'b1;
    @(negedge clk_i);
    inst_ready_i = 1'b0;
    chk("ev_done", 64'(ready_o), 64'(1));

    // Reset while a lookup is outstanding; the late response must be ignored
    fixed_delay = 3;
    img_mem.delete();
    b.iaddr = 32'h7000; b.iretire = 4; b.ls = 1; b.itype = 0; b.priv = 2;
    drive_blk(b);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrst_async", 64'({ready_o, any_out()}), 64'(2'b10));
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("midrst_release", 64'({ready_o, any_out()}), 64'(2'b10));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      chk("midrst_no_record", 64'({inst_valid_o, img_req_o, ready_o}), 64'(3'b001));
    end
    chk("midrst_stale_delivered", 64'(rsp_pend), 64'(0));

    // Randomized blocks against the model
    fixed_delay = -1;
    spurious_en = 1;
    for (int n = 0; n < 40; n++) begin
      tmp = $urandom();
      if (n % 8 == 0) tmp = 32'hFFFF_FFFE - XLEN'(2 * $urandom_range(0, 3));
      tmp[0] = 1'b0;
      b.iaddr   = tmp;
      b.iretire = IRL'($urandom_range(0, 7));
      b.ls      = 1'($urandom_range(0, 1));
      b.itype   = ITL'($urandom_range(0, 4));
      b.cause   = $urandom();
      b.tval    = $urandom();
      b.priv    = PL'($urandom_range(0, 3));
      img_mem.delete();
      for (int k = 0; k <= 16; k++) img_mem[b.iaddr + XLEN'(2 * k)] = 1'($urandom_range(0, 1));
      model_block(b);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      run_block(b, 60, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
